// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 4-digit BCD display scanner with one-entry value buffer
module display_scan_ctrl #(
    parameter int DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] valor_in,
    input  logic        valor_valid,
    output logic        valor_ready,
    input  logic        blank_ceros,
    output logic [3:0]  digito,
    output logic [3:0]  anodo,
    output logic        frame_done
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [15:0]     shadow;
    logic [15:0]     pend;
    logic            pend_full;
    logic [3:0]      digito_q;
    logic [3:0]      nib;
    logic            blank_slot;
    logic            cnt_last;
    logic            xfer;

    assign nib      = shadow[{idx, 2'b00} +: 4];
    assign cnt_last = (cnt == CNT_LAST);
    assign xfer     = valor_valid & valor_ready;

    // A digit is suppressed when it and every more significant nibble is zero.
    always_comb begin
        blank_slot = 1'b0;
        case (idx)
            2'd1:    blank_slot = blank_ceros && (shadow[15:4] == 12'h000);
            2'd2:    blank_slot = blank_ceros && (shadow[15:8] == 8'h00);
            2'd3:    blank_slot = blank_ceros && (shadow[15:12] == 4'h0);
            default: blank_slot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        valor_ready = 1'b1;
        anodo       = 4'b1111;
        digito      = digito_q;
        frame_done  = 1'b0;
        case (state)
            OFF: begin
                if (valor_valid) state_nxt = SHOW;
            end
            SHOW: begin
                valor_ready = ~pend_full;
                digito      = nib;
                if (!blank_slot) anodo = ~(4'b0001 << idx);
                if (cnt_last) state_nxt = GAP;
            end
            GAP: begin
                valor_ready = ~pend_full;
                frame_done  = (idx == 2'd3);
                state_nxt   = SHOW;
            end
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 2'd0;
            shadow    <= 16'h0000;
            pend      <= 16'h0000;
            pend_full <= 1'b0;
            digito_q  <= 4'h0;
        end else begin
            case (state)
                OFF: begin
                    if (xfer) begin
                        shadow <= valor_in;
                        idx    <= 2'd0;
                        cnt    <= '0;
                    end
                end
                SHOW: begin
                    // Remember the shown nibble so digito holds it through GAP.
                    digito_q <= nib;
                    cnt      <= cnt_last ? '0 : cnt + 1'b1;
                    if (xfer) begin
                        pend      <= valor_in;
                        pend_full <= 1'b1;
                    end
                end
                GAP: begin
                    idx <= idx + 2'd1;
                    // Frame boundary: the only point where shadow may change.
                    if (idx == 2'd3) begin
                        if (pend_full) begin
                            shadow    <= pend;
                            pend_full <= 1'b0;
                        end else if (xfer) begin
                            shadow <= valor_in;
                        end
                    end else if (xfer) begin
                        pend      <= valor_in;
                        pend_full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * (DIV + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] valor_in;
    logic        valor_valid;
    logic        valor_ready;
    logic        blank_ceros;
    logic [3:0]  digito;
    logic [3:0]  anodo;
    logic        frame_done;

    display_scan_ctrl #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valor_in    (valor_in),
        .valor_valid (valor_valid),
        .valor_ready (valor_ready),
        .blank_ceros (blank_ceros),
        .digito      (digito),
        .anodo       (anodo),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: position within a frame of 4*(DIV+1) cycles.
    bit          m_active;
    int          m_pos;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    bit          m_pend_v;
    logic [3:0]  m_last;

    logic [3:0] s_an, s_dig;
    logic       s_rdy, s_fd;

    typedef struct {
        int          n;
        logic        valid;
        logic [15:0] din;
        logic        blank;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic        rdy;
        logic        fd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_shown  = 16'h0;
        m_pend   = 16'h0;
        m_pend_v = 0;
        m_last   = 4'h0;
    endtask

    task automatic model_exp(output logic [3:0] an, output logic [3:0] dig,
                             output logic rdy, output logic fd);
        int          slot;
        logic [15:0] sh;
        rdy = !m_active || !m_pend_v;
        an  = 4'hF;
        dig = m_last;
        fd  = 1'b0;
        if (m_active) begin
            slot = m_pos / (DIV + 1);
            if ((m_pos % (DIV + 1)) == DIV) begin
                fd = (slot == 3);
            end else begin
                sh  = m_shown >> (4 * slot);
                dig = sh[3:0];
                if (!(blank_ceros && slot > 0 && sh == 16'h0)) an = ~(4'b0001 << slot);
            end
        end
    endtask

    task automatic model_step();
        logic [3:0] an, dig;
        logic       rdy, fd;
        bit         xfer;
        model_exp(an, dig, rdy, fd);
        xfer = valor_valid && rdy;
        if (!m_active) begin
            if (xfer) begin
                m_active = 1;
                m_pos    = 0;
                m_shown  = valor_in;
            end
        end else begin
            if ((m_pos % (DIV + 1)) != DIV) m_last = dig;
            if (m_pos == FRAME - 1) begin
                if (m_pend_v) begin
                    m_shown  = m_pend;
                    m_pend_v = 0;
                end else if (xfer) begin
                    m_shown = valor_in;
                end
            end else if (xfer) begin
                m_pend   = valor_in;
                m_pend_v = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic tick(input bit use_exp = 0, input logic [9:0] exp = 10'h0, input string nm = "vec");
        logic [3:0] ea, ed;
        logic       er, ef;
        @(negedge clk);
        s_an  = anodo;
        s_dig = digito;
        s_rdy = valor_ready;
        s_fd  = frame_done;
        model_exp(ea, ed, er, ef);
        check("model", 32'({anodo, digito, valor_ready, frame_done}), 32'({ea, ed, er, ef}));
        if (use_exp) check(nm, 32'({anodo, digito, valor_ready, frame_done}), 32'(exp));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        bit seen;
        int c_hi, c_d1, c_d0, c_lit, c_ok, c_fd;

        vecs[0] = '{4, 1'b0, 16'h0, 1'b0, 4'hE, 4'h4, 1'b1, 1'b0};
        vecs[1] = '{1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h4, 1'b1, 1'b0};
        vecs[2] = '{4, 1'b0, 16'h0, 1'b0, 4'hD, 4'h3, 1'b1, 1'b0};
        vecs[3] = '{1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h3, 1'b1, 1'b0};
        vecs[4] = '{4, 1'b0, 16'h0, 1'b0, 4'hB, 4'h2, 1'b1, 1'b0};
        vecs[5] = '{1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h2, 1'b1, 1'b0};
        vecs[6] = '{4, 1'b0, 16'h0, 1'b0, 4'h7, 4'h1, 1'b1, 1'b0};
        vecs[7] = '{1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h1, 1'b1, 1'b1};

        rst_n       = 1'b0;
        valor_in    = 16'h0;
        valor_valid = 1'b0;
        blank_ceros = 1'b0;
        model_reset();
        #12;
        check("reset_outputs", 32'({anodo, digito, valor_ready, frame_done}), 32'({4'hF, 4'h0, 1'b1, 1'b0}));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset: nothing lit, ready high, no frame pulse.
        for (int i = 0; i < 50; i++) tick(1, {4'hF, 4'h0, 1'b1, 1'b0}, "idle");

        // Load 1234 and check two full frames from the table.
        valor_valid = 1'b1;
        valor_in    = 16'h1234;
        tick();
        valor_valid = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 8; v++)
                for (int k = 0; k < vecs[v].n; k++) begin
                    valor_valid = vecs[v].valid;
                    valor_in    = vecs[v].din;
                    blank_ceros = vecs[v].blank;
                    tick(1, {vecs[v].an, vecs[v].dig, vecs[v].rdy, vecs[v].fd}, "frame1234");
                end

        // Mid-frame transfer goes to the pending buffer.
        for (int i = 0; i < 3; i++) tick();
        valor_valid = 1'b1;
        valor_in    = 16'h0042;
        tick();
        valor_valid = 1'b0;
        tick();
        check("pend_ready_low", 32'(s_rdy), 32'(1'b0));
        seen = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick();
            if (s_fd) begin
                seen = 1;
                break;
            end
        end
        check("frame_done_seen", 32'(seen), 32'(1'b1));
        tick();
        check("new_frame_digit0", 32'({s_an, s_dig, s_rdy}), 32'({4'hE, 4'h2, 1'b1}));
        for (int i = 0; i < FRAME - 1; i++) tick();

        // Leading-zero blanking on 0042.
        blank_ceros = 1'b1;
        c_hi = 0; c_d1 = 0; c_d0 = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (s_an[3:2] != 2'b11) c_hi++;
            if (s_an == 4'hD) c_d1++;
            if (s_an == 4'hE) c_d0++;
        end
        check("blank_hi_lit", 32'(c_hi), 32'(0));
        check("blank_d1_cycles", 32'(c_d1), 32'(DIV));
        check("blank_d0_cycles", 32'(c_d0), 32'(DIV));

        // All-zero value: only digit 0 lights, frame length unchanged.
        valor_valid = 1'b1;
        valor_in    = 16'h0000;
        tick();
        valor_valid = 1'b0;
        for (int i = 0; i < FRAME - 1; i++) tick();
        c_lit = 0; c_ok = 0; c_fd = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (s_an != 4'hF) c_lit++;
            if (s_an == 4'hE && s_dig == 4'h0) c_ok++;
            if (s_fd) c_fd++;
        end
        check("zero_lit_cycles", 32'(c_lit), 32'(DIV));
        check("zero_digit0_ok", 32'(c_ok), 32'(DIV));
        check("zero_frame_done", 32'(c_fd), 32'(1));

        // Transfer exactly on the last GAP cycle with the buffer empty.
        for (int i = 0; i < FRAME - 1; i++) tick();
        valor_valid = 1'b1;
        valor_in    = 16'h5678;
        tick();
        check("gap3_pulse_ready", 32'({s_fd, s_rdy}), 32'({1'b1, 1'b1}));
        valor_valid = 1'b0;
        tick();
        check("direct_load", 32'({s_an, s_dig, s_rdy}), 32'({4'hE, 4'h8, 1'b1}));

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            valor_valid = ($urandom_range(0, 3) == 0);
            valor_in    = 16'($urandom);
            if ($urandom_range(0, 1) == 1) valor_in[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) valor_in[7:4] = 4'h0;
            blank_ceros = 1'($urandom_range(0, 1));
            tick();
        end

        // Asynchronous reset mid-SHOW with the pending buffer full.
        valor_valid = 1'b1;
        valor_in    = 16'h9ABC;
        seen = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (m_pend_v && (m_pos % (DIV + 1)) != DIV) begin
                seen = 1;
                break;
            end
        end
        check("pend_full_reached", 32'(seen), 32'(1'b1));
        valor_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({anodo, digito, valor_ready, frame_done}), 32'({4'hF, 4'h0, 1'b1, 1'b0}));
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held", 32'({anodo, valor_ready, frame_done}), 32'({4'hF, 1'b1, 1'b0}));
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick(1, {4'hF, 4'h0, 1'b1, 1'b0}, "post_reset_idle");
        valor_valid = 1'b1;
        valor_in    = 16'hABCD;
        tick();
        valor_valid = 1'b0;
        tick();
        check("post_reset_load", 32'({s_an, s_dig}), 32'({4'hE, 4'hD}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 100000, meaning clock cycles each digit is lit per scan slot; legal range 2..2^20.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valor_in  input  16  four BCD nibbles; [3:0]=digit 0 (least significant) .. [15:12]=digit 3.
REQ-005 valor_valid  input  1  producer offers valor_in this cycle.
REQ-006 valor_ready  output  1  block accepts valor_in this cycle; transfer = valor_valid & valor_ready.
REQ-007 blank_ceros  input  1  1 = suppress leading-zero digits.
REQ-008 digito  output  4  BCD nibble of currently selected digit, feeds the BCD-to-cathode decoder.
REQ-009 anodo  output  4  active-low digit enables; anodo[i]=0 lights digit i.
REQ-010 frame_done  output  1  one-cycle pulse at end of each 4-digit scan frame.

Function
REQ-011 States SHALL be OFF (no value yet), SHOW (one digit lit), GAP (all anodes off, one cycle).
REQ-012 OFF: anodo=4'b1111, valor_ready=1; on transfer shadow<=valor_in, idx<=0, cnt<=0, next state SHOW.
REQ-013 SHOW: cnt counts 0..DIV-1; at cnt==DIV-1 next state GAP, cnt<=0; digit lit exactly DIV cycles.
REQ-014 GAP: anodo=4'b1111 for exactly one cycle; idx<=idx+1 mod 4 (3 wraps to 0); next state SHOW.
REQ-015 Frame length SHALL be 4*(DIV+1) cycles; no state returns to OFF except via reset.
REQ-016 In SHOW, digito=shadow[4*idx+3:4*idx], anodo=~(4'b0001<<idx); in OFF/GAP digito holds last value.
REQ-017 Nibbles 10..15 SHALL pass to digito unchanged; no range checking.
REQ-018 Leading-zero blanking: with blank_ceros=1, digit i (i=1..3) SHALL keep anodo[i]=1 during its slot if shadow nibbles i..3 are all zero; digit 0 never blanked; slot timing unchanged.
REQ-019 One-entry pending buffer: in SHOW/GAP valor_ready = ~pend_full; transfer loads pend and sets pend_full.
REQ-020 In the GAP cycle with idx==3: frame_done=1; if pend_full, shadow<=pend and pend_full<=0; valor_ready returns to 1 the following cycle.
REQ-021 Transfer coinciding with GAP idx==3 while pend_full=0 SHALL load shadow directly from valor_in; pend_full stays 0.
REQ-022 Transfer while pend_full=1 cannot occur (ready low); valor_valid with ready low SHALL be ignored, no state change.
REQ-023 New values SHALL take effect only at digit 0 of a frame; a frame never mixes two values.
REQ-024 frame_done SHALL be 0 in all other cycles, including OFF.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for clk, force: state OFF, cnt 0, idx 0, shadow 0, pend 0, pend_full 0, anodo 4'b1111, digito 4'h0, valor_ready 1, frame_done 0.
REQ-026 Reset asserted mid-frame or with pend_full=1 SHALL discard shadow and pending data; after release, block waits in OFF for a new transfer.
REQ-027 First rising edge after rst_n release SHALL be a normal operating edge.

Verification (DIV=4)
REQ-028 Reset release, valor_valid=0 for 50 cycles -> anodo stays 4'b1111, valor_ready=1, frame_done never 1.
REQ-029 Transfer 16'h1234, blank_ceros=0 -> per frame: digito 4 lit 4 cycles anodo 4'b1110, gap 1 cycle 4'b1111, then 3/1101, 2/1011, 1/0111; frame_done pulse every 20 cycles.
REQ-030 Mid-frame transfer 16'h0042 -> valor_ready low the next cycle; current frame finishes with 1234; next frame shows 2,4,0,0; ready high cycle after frame_done.
REQ-031 16'h0042 with blank_ceros=1 -> anodo[2] and anodo[3] stay 1 in their slots; 16'h0000 -> only digit 0 lit showing 0; frame still 20 cycles.
REQ-032 Transfer 16'h5678 exactly on the idx==3 GAP cycle, pend empty -> next cycle digito=8 with anodo 4'b1110, valor_ready stays 1.
REQ-033 rst_n low between clock edges mid-SHOW with pend_full=1 -> anodo 4'b1111 and valor_ready=1 before next edge; after release no digit lights until new transfer.
